// File: rtl/tonet_injection_arbiter_pkg.sv
// Shared flit-type encodings and arbiter state encodings for the ToNet injection arbiter.
package tonet_injection_arbiter_pkg;

  localparam logic [1:0] FlitHeader     = 2'd0;
  localparam logic [1:0] FlitBody       = 2'd1;
  localparam logic [1:0] FlitTail       = 2'd2;
  localparam logic [1:0] FlitHeaderTail = 2'd3;

  localparam logic ArbIdle   = 1'b0;
  localparam logic ArbLocked = 1'b1;

  typedef enum logic {
    StIdle   = ArbIdle,
    StLocked = ArbLocked
  } arb_state_e;

endpackage

// File: rtl/tonet_injection_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module tonet_injection_arbiter_rr_priority_picker #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic [NumReq-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  int k;

  // Scan from farthest to nearest so the nearest match is the last one written.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      k = (int'(ptr_i) + i) % int'(NumReq);
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = IdxWidth'(k);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tonet_injection_arbiter.sv
// Packet-granular round-robin arbiter sharing one injector port among N ToNets.
// Optional sticky protocol-error flag: define TONET_INJECTION_ARBITER_ERROR_EN.
module tonet_injection_arbiter
  import tonet_injection_arbiter_pkg::*;
#(
  parameter int unsigned NumberOfRequesters    = 4,
  parameter int unsigned RequesterIdWidth      = 2,
  parameter int unsigned FlitWidth             = 64,
  parameter int unsigned FlitTypeWidth         = 2,
  parameter int unsigned BroadcastWidth        = 1,
  parameter int unsigned VirtualChannelIdWidth = 3
) (
  input  logic                                                clk_i,
  input  logic                                                rst_i,
  input  logic [NumberOfRequesters-1:0]                       req_valid_i,
  output logic [NumberOfRequesters-1:0]                       req_ready_o,
  input  logic [NumberOfRequesters*FlitWidth-1:0]             req_flit_i,
  input  logic [NumberOfRequesters*FlitTypeWidth-1:0]         req_flit_type_i,
  input  logic [NumberOfRequesters*BroadcastWidth-1:0]        req_broadcast_i,
  input  logic [NumberOfRequesters*VirtualChannelIdWidth-1:0] req_virtual_channel_id_i,
  output logic                                                tlp_valid_o,
  input  logic                                                tlp_ready_i,
  output logic [FlitWidth-1:0]                                tlp_flit_o,
  output logic [FlitTypeWidth-1:0]                            tlp_flit_type_o,
  output logic [BroadcastWidth-1:0]                           tlp_broadcast_o,
  output logic [VirtualChannelIdWidth-1:0]                    tlp_virtual_channel_id_o,
  output logic [RequesterIdWidth-1:0]                         grant_id_o,
`ifdef TONET_INJECTION_ARBITER_ERROR_EN
  output logic                                                error_o,
`endif
  output logic                                                busy_o
);

  localparam int unsigned N = NumberOfRequesters;
  localparam logic [FlitTypeWidth-1:0] TypeHeader     = FlitTypeWidth'(FlitHeader);
  localparam logic [FlitTypeWidth-1:0] TypeTail       = FlitTypeWidth'(FlitTail);
  localparam logic [FlitTypeWidth-1:0] TypeHeaderTail = FlitTypeWidth'(FlitHeaderTail);

  arb_state_e                  state_q, state_d;
  logic [RequesterIdWidth-1:0] owner_q, owner_d;
  logic [RequesterIdWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [RequesterIdWidth-1:0] grant_q, grant_d;
  logic [N-1:0]                is_header, is_end, candidates, pick_gnt;
  logic [RequesterIdWidth-1:0] pick_idx, src;
  logic                        pick_valid, locked, xfer;

  function automatic logic [RequesterIdWidth-1:0] wrap_inc(
    input logic [RequesterIdWidth-1:0] idx
  );
    return (int'(idx) >= int'(N) - 1) ? '0 : idx + RequesterIdWidth'(1);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_decode
    logic [FlitTypeWidth-1:0] ftype;
    assign ftype        = req_flit_type_i[g*FlitTypeWidth +: FlitTypeWidth];
    assign is_header[g] = (ftype == TypeHeader) || (ftype == TypeHeaderTail);
    assign is_end[g]    = (ftype == TypeTail) || (ftype == TypeHeaderTail);
  end

  assign candidates = req_valid_i & is_header;

  tonet_injection_arbiter_rr_priority_picker #(
    .NumReq  (N),
    .IdxWidth(RequesterIdWidth)
  ) u_picker (
    .req_i  (candidates),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  assign locked = (state_q == StLocked);
  assign src    = locked ? owner_q : pick_idx;

  always_comb begin
    tlp_valid_o              = 1'b0;
    req_ready_o              = '0;
    tlp_flit_o               = '0;
    tlp_flit_type_o          = '0;
    tlp_broadcast_o          = '0;
    tlp_virtual_channel_id_o = '0;
    if (!rst_i && (locked || pick_valid)) begin
      tlp_flit_o      = req_flit_i[int'(src)*FlitWidth +: FlitWidth];
      tlp_flit_type_o = req_flit_type_i[int'(src)*FlitTypeWidth +: FlitTypeWidth];
      tlp_broadcast_o = req_broadcast_i[int'(src)*BroadcastWidth +: BroadcastWidth];
      tlp_virtual_channel_id_o =
        req_virtual_channel_id_i[int'(src)*VirtualChannelIdWidth +: VirtualChannelIdWidth];
      if (locked) begin
        tlp_valid_o      = req_valid_i[src];
        req_ready_o[src] = tlp_ready_i;
      end else begin
        tlp_valid_o = 1'b1;
        req_ready_o = pick_gnt & {N{tlp_ready_i}};
      end
    end
  end

  assign xfer   = tlp_valid_o && tlp_ready_i;
  assign busy_o = !rst_i && locked;

  // Grant id remembers the last selection while idle with nothing to pick.
  always_comb begin
    if (rst_i) begin
      grant_id_o = '0;
    end else if (locked) begin
      grant_id_o = owner_q;
    end else if (pick_valid) begin
      grant_id_o = pick_idx;
    end else begin
      grant_id_o = grant_q;
    end
  end
  assign grant_d = grant_id_o;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      unique case (state_q)
        StIdle: begin
          if (is_end[pick_idx]) begin
            rr_ptr_d = wrap_inc(pick_idx);
          end else begin
            state_d = StLocked;
            owner_d = pick_idx;
          end
        end
        StLocked: begin
          if (is_end[owner_q]) begin
            state_d  = StIdle;
            rr_ptr_d = wrap_inc(owner_q);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

`ifdef TONET_INJECTION_ARBITER_ERROR_EN
  logic error_q, error_d, error_hit;

  always_comb begin
    if (locked) begin
      error_hit = req_valid_i[owner_q] && is_header[owner_q];
    end else begin
      error_hit = |(req_valid_i & ~is_header);
    end
    error_d = error_q | error_hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error_o = error_q;
`endif

endmodule
